// File: rtl/memwrite_pkg.sv
// ============================================================================
// memwrite_pkg -- shared widths, state encoding and helpers for the memWrite
// sequential unsigned divider.                                     Rev 1.0
// ============================================================================
`default_nettype none

package memwrite_pkg;

  localparam int DIVIDEND_W = 30;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 14;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ITER_W = clog2_min1(QUOT_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/memwrite_udiv_step.sv
// ============================================================================
// memwrite_udiv_step -- one combinational restoring-division step.
//                                                                  Rev 1.0
// ============================================================================
`default_nettype none

module memwrite_udiv_step #(
  parameter int W = 31
) (
  input  logic [W-1:0] partial_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] partial_o,
  output logic         qbit_o
);

  assign qbit_o    = (partial_i >= dvsr_i);
  assign partial_o = qbit_o ? (partial_i - dvsr_i) : partial_i;

endmodule

`default_nettype wire

// File: rtl/memwrite_udiv_seq.sv
// ============================================================================
// memwrite_udiv_seq -- sequential restoring divider, one quotient bit/cycle.
// Optional MEMWRITE_UDIV_POW2_FASTPATH_EN: power-of-two divisors skip RUN.
//                                                                  Rev 1.0
// ============================================================================
`default_nettype none

module memwrite_udiv_seq
  import memwrite_pkg::*;
#(
  parameter int DIVIDEND_W = memwrite_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = memwrite_pkg::DIVISOR_W,
  parameter int QUOT_W     = memwrite_pkg::QUOT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  div0,
  output logic                  ovf
);

  localparam int CMP_W = DIVISOR_W + QUOT_W + 1;
  localparam int CNT_W = clog2_min1(QUOT_W);

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] part_q, part_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  div0_q, div0_d;
  logic                  ovf_q, ovf_d;

  logic [CMP_W-1:0]      step_part, step_dvsr, step_next;
  logic                  step_qbit;
  logic                  in_xfer, out_xfer, too_big;

  assign in_ready  = ce & (state_q == S_IDLE);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_xfer  = out_valid & out_ready & ce;

  assign quot = quot_q;
  assign rem  = rem_q;
  assign div0 = div0_q;
  assign ovf  = ovf_q;

  // Comparisons run at CMP_W bits so divisor << QUOT_W never truncates.
  assign step_part = CMP_W'(part_q);
  assign step_dvsr = CMP_W'(dvsr_q) << cnt_q;
  assign too_big   = (CMP_W'(part_q) >= (CMP_W'(dvsr_q) << QUOT_W));

  memwrite_udiv_step #(.W(CMP_W)) u_step (
    .partial_i (step_part),
    .dvsr_i    (step_dvsr),
    .partial_o (step_next),
    .qbit_o    (step_qbit)
  );

`ifdef MEMWRITE_UDIV_POW2_FASTPATH_EN
  int   fp_shift;
  logic is_pow2;

  assign is_pow2 = ((dvsr_q & (dvsr_q - 1'b1)) == '0);

  always_comb begin
    fp_shift = 0;
    for (int b = 0; b < DIVISOR_W; b++) begin
      if (dvsr_q[b]) fp_shift = b;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          part_d  = dividend;
          dvsr_d  = divisor;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dvsr_q == '0) begin
          div0_d  = 1'b1;
          ovf_d   = 1'b0;
          quot_d  = '1;
          rem_d   = '0;
          state_d = S_DONE;
        end else if (too_big) begin
          div0_d  = 1'b0;
          ovf_d   = 1'b1;
          quot_d  = '1;
          rem_d   = '0;
          state_d = S_DONE;
`ifdef MEMWRITE_UDIV_POW2_FASTPATH_EN
        end else if (is_pow2) begin
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          quot_d  = QUOT_W'(part_q >> fp_shift);
          rem_d   = DIVISOR_W'(part_q) & (dvsr_q - 1'b1);
          state_d = S_DONE;
`endif
        end else begin
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          quot_d  = '0;
          cnt_d   = CNT_W'(QUOT_W - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        part_d         = DIVIDEND_W'(step_next);
        quot_d[cnt_q]  = step_qbit;
        if (cnt_q == '0) begin
          rem_d   = DIVISOR_W'(step_next);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      part_q  <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      part_q  <= part_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memwrite_udiv_seq.sv
// ============================================================================
// tb_memwrite_udiv_seq -- self-checking bench: directed cases plus randomized
// operands compared against an arithmetic reference model.         Rev 1.0
// ============================================================================
`default_nettype none

module tb_memwrite_udiv_seq;

  localparam int DW = 30;
  localparam int VW = 16;
  localparam int QW = 14;

`ifdef MEMWRITE_UDIV_POW2_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          ce        = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dividend  = '0;
  logic [VW-1:0] divisor   = '0;
  logic          in_ready, out_valid, div0, ovf;
  logic [QW-1:0] quot;
  logic [VW-1:0] rem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  memwrite_udiv_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div0      (div0),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the error and latency rules.
  task automatic model(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                       output logic [QW-1:0] q, output logic [VW-1:0] r,
                       output logic d0, output logic ov, output int lat);
    longint unsigned a, b;
    a  = dd;
    b  = dv;
    d0 = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      d0 = 1'b1; q = '1; r = '0; lat = 2;
    end else if (a >= b * 64'(1 << QW)) begin
      ov = 1'b1; q = '1; r = '0; lat = 2;
    end else begin
      q   = QW'(a / b);
      r   = VW'(a % b);
      lat = (FAST && ((b & (b - 1)) == 0)) ? 2 : QW + 2;
    end
  endtask

  task automatic do_op(input string tag, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                       input int stall_at, input int hold);
    logic [QW-1:0] eq;
    logic [VW-1:0] er;
    logic          ed0, eov;
    int            elat, lat, w;
    model(dd, dv, eq, er, ed0, eov, elat);
    if (stall_at > 0) elat += 5;
    @(negedge ap_clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge ap_clk); w++; end
    check({tag, "_in_ready"}, in_ready, 1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    check({tag, "_busy"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (stall_at > 0 && lat == stall_at)     ce = 1'b0;
      if (stall_at > 0 && lat == stall_at + 5) ce = 1'b1;
      @(negedge ap_clk);
      lat++;
    end
    ce = 1'b1;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"},  rem,  er);
    check({tag, "_flags"}, {div0, ovf}, {ed0, eov});
    for (int h = 0; h < hold; h++) begin
      @(negedge ap_clk);
      check({tag, "_hold"}, {out_valid, in_ready, quot, rem, div0, ovf},
            {1'b1, 1'b0, eq, er, ed0, eov});
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [DW-1:0] rdd;
    logic [VW-1:0] rdv;
    int            seen;

    repeat (3) @(negedge ap_clk);
    check("rst_outputs", {out_valid, quot, rem, div0, ovf}, '0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_in_ready", in_ready, 1);

    do_op("basic",    30'd1000,       16'd7,     0, 0);
    do_op("maxlegal", 30'd1073725439, 16'd65535, 0, 0);
    do_op("ovf",      30'd16384,      16'd1,     0, 0);
    do_op("div0",     30'd5,          16'd0,     0, 0);
    do_op("hold",     30'd1000,       16'd7,     0, 10);
    do_op("second",   30'd99,         16'd10,    0, 0);
    do_op("stall",    30'd1000,       16'd7,     5, 0);

    // Reset pulse mid-RUN must abort the operation without a result.
    @(negedge ap_clk);
    dividend = 30'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_outputs", {out_valid, quot, rem, div0, ovf}, '0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ap_clk);
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);

    do_op("pow2", 30'd1000, 16'd8, 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin rdv = '0; rdd = DW'($urandom); end
        1: begin
             rdv = VW'(1 << $urandom_range(0, VW - 1));
             rdd = DW'($urandom_range(0, (int'(rdv) << QW) - 1));
           end
        2: begin rdv = VW'($urandom); rdd = DW'($urandom); end
        default: begin
             rdv = VW'($urandom_range(1, 255));
             rdd = DW'($urandom_range(0, (int'(rdv) << QW) - 1));
           end
      endcase
      do_op("rand", rdd, rdv, 0, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memwrite_udiv_seq.md
Name: memwrite_udiv_seq

Overview:
- Sequential unsigned divider for the memWrite path; inverse of the 14x16->30 product used for address generation on the read side.
- Splits a 30-bit linear output index by a 16-bit dimension into quotient (14-bit row/channel index) and remainder (16-bit offset) so memWrite can form tiled write addresses.
- Restoring division, one quotient bit per cycle, valid/ready on both sides, global clock enable matching the multiplier primitives.

Parameters:
- DIVIDEND_W, 30, dividend width
- DIVISOR_W, 16, divisor and remainder width
- QUOT_W, 14, quotient width; also the number of RUN iterations

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; 0 freezes all state, including handshakes
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- dividend  in  DIVIDEND_W  numerator
- divisor  in  DIVISOR_W  denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quot  out  QUOT_W  quotient
- rem  out  DIVISOR_W  remainder
- div0  out  1  divisor was zero
- ovf  out  1  true quotient >= 2^QUOT_W

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid, quot, rem, div0, ovf = 0; in_ready=1 after release.
- in_ready = ce & (state==IDLE). Input transfer = in_valid & in_ready; operands are latched in that cycle.
- Output transfer = out_valid & out_ready & ce. quot, rem, div0 and ovf stay stable while out_valid=1.
- States:
  - IDLE: on input transfer, go to CHECK.
  - CHECK: if divisor==0, set div0=1, quot=all ones, rem=0, go to DONE. Else if dividend >= (divisor << QUOT_W), set ovf=1, quot=all ones, rem=0, go to DONE. Else clear the flags, set i=QUOT_W-1, go to RUN.
  - RUN: if partial >= (divisor << i), subtract and set quot[i]=1, else set quot[i]=0. Decrement i; after i=0, go to DONE with rem=partial.
  - DONE: out_valid=1. On output transfer, go to IDLE and drop out_valid.
- Latency: input transfer at cycle T gives out_valid at T+QUOT_W+2 on the normal path, and at T+2 on the error paths, counting ce=1 cycles only.
- No input is accepted while busy; back-to-back throughput is one operation per QUOT_W+3 cycles.
- Partial remainder is DIVIDEND_W bits wide. Comparisons are done at DIVISOR_W+QUOT_W+1 bits, so there is no truncation.
- ce=0 mid-RUN: iteration counter and partial remainder hold.
- ap_rst_n asserted mid-operation aborts the operation immediately; no result is produced.
- div0 takes priority over ovf; both are never set together.

Optional Feature:
- Macro: MEMWRITE_UDIV_POW2_FASTPATH_EN.
- Defined: in CHECK, a nonzero power-of-two divisor 2^k with no overflow goes straight to DONE.
  - quot = dividend >> k
  - rem = dividend & (2^k - 1)
  - Latency is T+2.
- Undefined: all nonzero divisors take the RUN path. Results are identical in both builds; only latency differs.

Decomposition:
- Package memwrite_pkg holds:
  - default width constants DIVIDEND_W/DIVISOR_W/QUOT_W
  - state enum (IDLE, CHECK, RUN, DONE)
  - clog2-based iteration-counter width constant
- Optional sub-module memwrite_udiv_step: combinational single restoring step (partial, shifted divisor -> next partial, quotient bit). The FSM and registers stay in the top module.

Test Plan:
- Basic: dividend=1000, divisor=7 -> quot=142, rem=6, flags 0; out_valid exactly QUOT_W+2=16 cycles after accept.
- Max legal: dividend=1073725439, divisor=65535 -> quot=16383, rem=65534, ovf=0.
- Errors:
  - dividend=16384, divisor=1 -> ovf=1, quot=16383, rem=0, result at T+2.
  - divisor=0, dividend=5 -> div0=1, ovf=0.
- Handshake:
  - hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout.
  - then out_ready=1 -> in_ready=1 next cycle; a second op (99/10 -> 9 rem 9) completes correctly.
- Stall and reset:
  - ce=0 for 5 cycles mid-RUN on 1000/7 -> result delayed exactly 5 cycles, still 142 rem 6.
  - ap_rst_n pulsed mid-RUN -> out_valid=0, quot=rem=0, in_ready=1 after release.
- Fastpath: 1000/8 -> quot=125, rem=0. With MEMWRITE_UDIV_POW2_FASTPATH_EN defined, latency is 2; without it, latency is 16.
